fdc_stim_gen: RTL and testbench

FDC_STIM_GEN -- requirements
Module: fdc_stim_gen

---
 rtl/fdc_pkg.sv | 27 ++
 rtl/fdc_divider.sv | 43 ++++
 rtl/fdc_stim_gen.sv | 157 +++++++++++++++
 tb/tb_fdc_stim_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared types and widths for the FDC stimulus generator.
package fdc_pkg;

   localparam int unsigned REF_DIV_W = 8;
   localparam int unsigned SIG_DIV_W = 8;
   localparam int unsigned PW_W      = 4;
   localparam int unsigned CNT_W     = 8;
   // Phase counter holds up to P-1 = ref_div+1, so it needs one extra bit.
   localparam int unsigned PH_W      = REF_DIV_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fdc_state_e;

   // Reference pulse width: requested width, clamped so at least one low cycle per period.
   function automatic logic [PH_W-1:0] pulse_width(input logic [REF_DIV_W-1:0] ref_div,
                                                   input logic [PW_W-1:0]      pulse_w);
      logic [PH_W-1:0] req;
      logic [PH_W-1:0] lim;
      req = PH_W'(pulse_w) + PH_W'(1);
      lim = PH_W'(ref_div) + PH_W'(1);
      return (req < lim) ? req : lim;
   endfunction

endpackage

// File: rtl/fdc_divider.sv
// Programmable modulo counter: counts 0..i_max while enabled, wraps to 0 with a strobe.
module fdc_divider
   import fdc_pkg::*;
#(
   parameter int unsigned Width = PH_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [Width-1:0] i_max,
   output logic [Width-1:0] o_count,
   output logic             o_wrap
);

   logic [Width-1:0] r_count;
   logic [Width-1:0] w_count_d;

   assign o_count = r_count;
   assign o_wrap  = i_en && !i_clr && (r_count == i_max);

   // Next count: clear wins, then wrap, then increment.
   always_comb begin
      w_count_d = r_count;
      if (i_clr) begin
         w_count_d = '0;
      end else if (o_wrap) begin
         w_count_d = '0;
      end else if (i_en) begin
         w_count_d = r_count + Width'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_d;
      end
   end

endmodule

// File: rtl/fdc_stim_gen.sv
// Stimulus generator for an FDC: emits a reference pulse train and a square wave.
module fdc_stim_gen
   import fdc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [REF_DIV_W-1:0] cfg_ref_div,
   input  logic [SIG_DIV_W-1:0] cfg_sig_div,
   input  logic [PW_W-1:0]      cfg_pulse_w,
   input  logic [CNT_W-1:0]     cfg_count,
   input  logic                 stop,
   output logic                 ref_pulse,
   output logic                 sig_out,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     pulse_cnt
);

   fdc_state_e           r_state;
   fdc_state_e           w_state_d;
   logic [REF_DIV_W-1:0] r_ref_div;
   logic [SIG_DIV_W-1:0] r_sig_div;
   logic [PW_W-1:0]      r_pulse_w;
   logic [CNT_W-1:0]     r_count;
   logic                 r_stop_req;
   logic [CNT_W-1:0]     r_pulse_cnt;
   logic                 r_cfg_ready;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_ref_pulse;
   logic                 r_sig_out;

   logic                 w_accept;
   logic                 w_run_en;
   logic                 w_ph_wrap;
   logic                 w_half_wrap;
   logic                 w_last;
   logic [PH_W-1:0]      w_phase;
   logic [PH_W-1:0]      w_phase_nxt;
   logic [PH_W-1:0]      w_width_d;
   logic [SIG_DIV_W-1:0] w_half;
   logic                 w_sig_d;
   logic                 w_unused_half;

   assign w_accept = ena && cfg_valid && (r_state == ST_IDLE);
   assign w_run_en = ena && (r_state == ST_RUN);
   // Final period: counted run reached N, or a stop is pending or arriving now.
   assign w_last   = r_stop_req || stop || ((r_count != '0) && (r_pulse_cnt == r_count));

   // Half-period counter is only needed for its wrap strobe.
   assign w_unused_half = ^w_half;

   fdc_divider #(
      .Width (PH_W)
   ) u_phase_div (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_run_en),
      .i_clr   (w_accept),
      .i_max   (PH_W'(r_ref_div) + PH_W'(1)),
      .o_count (w_phase),
      .o_wrap  (w_ph_wrap)
   );

   fdc_divider #(
      .Width (SIG_DIV_W)
   ) u_half_div (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_run_en),
      .i_clr   (w_accept),
      .i_max   (r_sig_div),
      .o_count (w_half),
      .o_wrap  (w_half_wrap)
   );

   // FSM next state; the state register only advances when ena is high.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_d = ST_RUN;
         ST_RUN:  if (w_ph_wrap && w_last) w_state_d = ST_DONE;
         ST_DONE: w_state_d = ST_IDLE;
         default: w_state_d = ST_IDLE;
      endcase
   end

   // Next-cycle phase and width, so outputs can be registered rather than decoded.
   always_comb begin
      w_phase_nxt = (w_accept || w_ph_wrap) ? '0 : w_phase + PH_W'(1);
      w_width_d   = w_accept ? pulse_width(cfg_ref_div, cfg_pulse_w)
                             : pulse_width(r_ref_div, r_pulse_w);
      w_sig_d     = 1'b0;
      if (w_state_d == ST_RUN && !w_accept) begin
         w_sig_d = w_half_wrap ? ~r_sig_out : r_sig_out;
      end
   end

   // Control state, latched configuration and pulse counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ref_div   <= '0;
         r_sig_div   <= '0;
         r_pulse_w   <= '0;
         r_count     <= '0;
         r_stop_req  <= 1'b0;
         r_pulse_cnt <= '0;
      end else if (ena) begin
         r_state <= w_state_d;
         if (w_accept) begin
            r_ref_div <= cfg_ref_div;
            r_sig_div <= cfg_sig_div;
            r_pulse_w <= cfg_pulse_w;
            r_count   <= cfg_count;
         end
         if (w_accept || w_state_d != ST_RUN) begin
            r_stop_req <= 1'b0;
         end else if (stop) begin
            r_stop_req <= 1'b1;
         end
         if (w_accept) begin
            r_pulse_cnt <= '0;
         end else if (w_run_en && w_phase == '0) begin
            r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
         end
      end
   end

   // Output registers, loaded from next-state values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ref_pulse <= 1'b0;
         r_sig_out   <= 1'b0;
      end else if (ena) begin
         r_cfg_ready <= (w_state_d == ST_IDLE);
         r_busy      <= (w_state_d == ST_RUN);
         r_done      <= (w_state_d == ST_DONE);
         r_ref_pulse <= (w_state_d == ST_RUN) && (w_phase_nxt < w_width_d);
         r_sig_out   <= w_sig_d;
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign ref_pulse = r_ref_pulse;
   assign sig_out   = r_sig_out;
   assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_fdc_stim_gen.sv
// Directed bench for fdc_stim_gen: table of counted runs plus hand-written corner sequences.
module tb_fdc_stim_gen;

   logic       clk = 1'b0;
   logic       rst, ena, cfg_valid, cfg_ready, stop;
   logic [7:0] cfg_ref_div, cfg_sig_div, cfg_count, pulse_cnt;
   logic [3:0] cfg_pulse_w;
   logic       ref_pulse, sig_out, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0]  ref_div;
      logic [7:0]  sig_div;
      logic [3:0]  pw;
      logic [7:0]  cnt;
      int          done_at;   // cycles after the accept edge until done shows
      logic [31:0] ref_pat;   // bit k = ref_pulse in cycle k after accept
      logic [31:0] sig_pat;   // bit k = sig_out in cycle k after accept
      logic [7:0]  final_cnt;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   fdc_stim_gen dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ref_div (cfg_ref_div),
      .cfg_sig_div (cfg_sig_div),
      .cfg_pulse_w (cfg_pulse_w),
      .cfg_count   (cfg_count),
      .stop        (stop),
      .ref_pulse   (ref_pulse),
      .sig_out     (sig_out),
      .busy        (busy),
      .done        (done),
      .pulse_cnt   (pulse_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Packs {cfg_ready, busy, done, ref_pulse, sig_out}.
   function automatic logic [31:0] flags();
      return {27'd0, cfg_ready, busy, done, ref_pulse, sig_out};
   endfunction

   function automatic logic [31:0] fl(input logic r, input logic b, input logic d,
                                      input logic p, input logic s);
      return {27'd0, r, b, d, p, s};
   endfunction

   task automatic set_cfg(input int i);
      cfg_ref_div = vecs[i].ref_div;
      cfg_sig_div = vecs[i].sig_div;
      cfg_pulse_w = vecs[i].pw;
      cfg_count   = vecs[i].cnt;
   endtask

   task automatic set_raw(input logic [7:0] rd, input logic [7:0] sd, input logic [3:0] pw,
                          input logic [7:0] cnt);
      cfg_ref_div = rd;
      cfg_sig_div = sd;
      cfg_pulse_w = pw;
      cfg_count   = cnt;
   endtask

   // Called at cycle 0 (just after the accept edge); ends in the IDLE cycle after DONE.
   task automatic check_vec(input int i);
      for (int k = 0; k < vecs[i].done_at; k++) begin
         chk($sformatf("v%0d cyc%0d flags", i, k), flags(),
             fl(1'b0, 1'b1, 1'b0, vecs[i].ref_pat[k], vecs[i].sig_pat[k]));
         tick();
      end
      chk($sformatf("v%0d done flags", i), flags(), fl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk($sformatf("v%0d done pulse_cnt", i), 32'(pulse_cnt), 32'(vecs[i].final_cnt));
      tick();
      chk($sformatf("v%0d idle flags", i), flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      chk($sformatf("v%0d idle pulse_cnt", i), 32'(pulse_cnt), 32'(vecs[i].final_cnt));
   endtask

   task automatic accept();
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'd3, 8'd1, 4'd0,  8'd3, 15, 32'h0421, 32'h4CCC, 8'd3};
      vecs[1] = '{8'd0, 8'd0, 4'd15, 8'd2, 4,  32'h0005, 32'h000A, 8'd2};
      vecs[2] = '{8'd2, 8'd2, 4'd1,  8'd2, 8,  32'h0033, 32'h0038, 8'd2};
      vecs[3] = '{8'd4, 8'd3, 4'd2,  8'd1, 6,  32'h0007, 32'h0030, 8'd1};
      vecs[4] = '{8'd1, 8'd5, 4'd5,  8'd2, 6,  32'h001B, 32'h0000, 8'd2};

      rst = 1'b1; ena = 1'b0; cfg_valid = 1'b0; stop = 1'b0;
      set_raw(8'd0, 8'd0, 4'd0, 8'd0);

      // Reset overrides ena low.
      tick();
      chk("reset flags", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("reset pulse_cnt", 32'(pulse_cnt), 32'd0);
      rst = 1'b0;

      // No transfer while ena is low.
      set_cfg(0);
      cfg_valid = 1'b1;
      tick();
      tick();
      chk("ena low blocks accept", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      cfg_valid = 1'b0;
      ena = 1'b1;
      tick();

      // Table of counted runs.
      for (int i = 0; i < 5; i++) begin
         set_cfg(i);
         accept();
         check_vec(i);
      end

      // Stop in IDLE is ignored.
      stop = 1'b1;
      tick();
      tick();
      stop = 1'b0;
      chk("stop in idle", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

      // Continuous run stopped at phase 2 of period 4.
      set_raw(8'd3, 8'd1, 4'd0, 8'd0);
      accept();
      repeat (17) tick();
      chk("stop pre pulse_cnt", 32'(pulse_cnt), 32'd4);
      chk("stop pre busy", 32'(busy), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("stop period finishing", flags(), fl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      tick();
      chk("stop done flags", flags(), fl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("stop done pulse_cnt", 32'(pulse_cnt), 32'd4);
      tick();
      chk("stop back idle", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

      // ena low for 4 cycles mid-run delays done by exactly 4.
      set_cfg(0);
      accept();
      repeat (5) tick();
      chk("freeze pre flags", flags(), fl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      ena = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("freeze cyc%0d flags", k), flags(), fl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
         chk($sformatf("freeze cyc%0d pulse_cnt", k), 32'(pulse_cnt), 32'd1);
      end
      ena = 1'b1;
      repeat (9) tick();
      chk("freeze not yet done", flags(), fl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      tick();
      chk("freeze done flags", flags(), fl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("freeze done pulse_cnt", 32'(pulse_cnt), 32'd3);
      tick();

      // Reset at phase 1 of period 2, then a fresh run.
      set_cfg(0);
      accept();
      repeat (6) tick();
      chk("rst pre pulse_cnt", 32'(pulse_cnt), 32'd2);
      rst = 1'b1;
      ena = 1'b0;
      tick();
      chk("rst mid-run flags", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("rst mid-run pulse_cnt", 32'(pulse_cnt), 32'd0);
      rst = 1'b0;
      ena = 1'b1;
      tick();
      chk("rst stays idle", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      set_cfg(0);
      accept();
      chk("restart pulse_cnt", 32'(pulse_cnt), 32'd0);
      check_vec(0);

      // cfg_valid held with new values during a run: ignored until IDLE.
      set_cfg(2);
      cfg_valid = 1'b1;
      tick();
      set_cfg(1);
      check_vec(2);
      tick();
      cfg_valid = 1'b0;
      check_vec(1);

      // Continuous pulse_cnt wrap 255 -> 0, stop arriving on the wrap edge.
      set_raw(8'd0, 8'd0, 4'd0, 8'd0);
      accept();
      repeat (510) tick();
      chk("wrap pulse_cnt 255", 32'(pulse_cnt), 32'd255);
      tick();
      chk("wrap pulse_cnt 0", 32'(pulse_cnt), 32'd0);
      chk("wrap still busy", 32'(busy), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("wrap stop done", flags(), fl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      chk("wrap stop idle", flags(), fl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
